// File: rtl/ebi_pkg.sv
// Shared EBI definitions: M1->M2 virtual-channel ids, per-channel message lengths,
// credit depth and scheduler state type.
package ebi_pkg;

  localparam int unsigned M1_M2_CHANNEL_NUM       = 5;
  localparam int unsigned M1_M2_CHANNEL_NUM_WIDTH = $clog2(M1_M2_CHANNEL_NUM);

  typedef enum logic [M1_M2_CHANNEL_NUM_WIDTH-1:0] {
    ID_AR = 0,
    ID_AW = 1,
    ID_W  = 2,
    ID_CR = 3,
    ID_CD = 4
  } m1_m2_channel_id_t;

  localparam int unsigned AR_MESSAGE_LENGTH = 24;
  localparam int unsigned AW_MESSAGE_LENGTH = 24;
  localparam int unsigned W_MESSAGE_LENGTH  = 40;
  localparam int unsigned CR_MESSAGE_LENGTH = 12;
  localparam int unsigned CD_MESSAGE_LENGTH = 36;

  localparam int unsigned MAX_M1_M2_MESSAGE_LENGTH = 40;

  localparam int unsigned M1_M2_CHANNEL_LENGTH_LIST [M1_M2_CHANNEL_NUM] = '{
    AR_MESSAGE_LENGTH, AW_MESSAGE_LENGTH, W_MESSAGE_LENGTH,
    CR_MESSAGE_LENGTH, CD_MESSAGE_LENGTH
  };

  localparam int unsigned VC_BUFFER_DEPTH = 4;

  localparam int unsigned TX_LEN_WIDTH = $clog2(MAX_M1_M2_MESSAGE_LENGTH + 1);

  typedef enum logic {
    SCH_IDLE = 1'b0,
    SCH_HOLD = 1'b1
  } sch_state_t;

  // Payload bit count of a VC; unknown ids report zero.
  function automatic logic [TX_LEN_WIDTH-1:0] chan_len(input int unsigned id);
    if (id < M1_M2_CHANNEL_NUM) begin
      return TX_LEN_WIDTH'(M1_M2_CHANNEL_LENGTH_LIST[id]);
    end
    return '0;
  endfunction

endpackage

// File: rtl/ebi_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping, wins.
module ebi_rr_arbiter #(
  parameter int unsigned N = 5,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic        found;
  int unsigned idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/ebi_m1m2_vc_scheduler.sv
// M1->M2 virtual-channel scheduler: credit-gated round-robin selection of one channel
// message at a time, held on the tx_* interface until the serial sender accepts it.
module ebi_m1m2_vc_scheduler
  import ebi_pkg::*;
#(
  parameter int unsigned NUM_CH   = M1_M2_CHANNEL_NUM,
  parameter int unsigned MSG_W    = MAX_M1_M2_MESSAGE_LENGTH,
  parameter int unsigned CRD_INIT = VC_BUFFER_DEPTH,
  localparam int unsigned CRD_W   = $clog2(CRD_INIT + 1),
  localparam int unsigned IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_CH-1:0]                  ch_valid_i,
  input  logic [NUM_CH*MSG_W-1:0]            ch_msg_i,
  output logic [NUM_CH-1:0]                  ch_ready_o,
  output logic                               tx_valid_o,
  input  logic                               tx_ready_i,
  output logic [M1_M2_CHANNEL_NUM_WIDTH-1:0] tx_vc_id_o,
  output logic [TX_LEN_WIDTH-1:0]            tx_len_o,
  output logic [MSG_W-1:0]                   tx_msg_o,
  input  logic                               crd_ret_valid_i,
  input  logic [M1_M2_CHANNEL_NUM_WIDTH-1:0] crd_ret_vc_i,
  output logic [NUM_CH*CRD_W-1:0]            crd_cnt_o,
  output logic                               crd_err_o
);

  sch_state_t                         state_q, state_d;
  logic [IDX_W-1:0]                   rr_ptr_q, rr_ptr_d;
  logic [CRD_W-1:0]                   crd_q [NUM_CH];
  logic [CRD_W-1:0]                   crd_d [NUM_CH];
  logic                               crd_err_q, crd_err_d;
  logic [M1_M2_CHANNEL_NUM_WIDTH-1:0] tx_vc_q;
  logic [TX_LEN_WIDTH-1:0]            tx_len_q;
  logic [MSG_W-1:0]                   tx_msg_q;

  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_en;

  always_comb begin
    elig = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      elig[k] = ch_valid_i[k] && (crd_q[k] != '0);
    end
  end

  ebi_rr_arbiter #(
    .N (NUM_CH)
  ) u_arb (
    .req     (elig),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign gnt_en     = (state_q == SCH_IDLE) && (|elig);
  assign ch_ready_o = gnt_en ? gnt : '0;
  assign tx_valid_o = (state_q == SCH_HOLD);
  assign tx_vc_id_o = tx_vc_q;
  assign tx_len_o   = tx_len_q;
  assign tx_msg_o   = tx_msg_q;
  assign crd_err_o  = crd_err_q;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      SCH_IDLE: begin
        if (gnt_en) begin
          state_d  = SCH_HOLD;
          rr_ptr_d = (32'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
        end
      end
      SCH_HOLD: begin
        // No grant on the accept cycle: messages are at least two cycles apart.
        if (tx_ready_i) begin
          state_d = SCH_IDLE;
        end
      end
      default: state_d = SCH_IDLE;
    endcase
  end

  // A return and a grant on the same VC cancel; a return to a full VC is dropped.
  always_comb begin
    logic ret_hit;
    logic inc;
    logic dec;
    crd_err_d = crd_err_q;
    if (crd_ret_valid_i && (32'(crd_ret_vc_i) >= NUM_CH)) begin
      crd_err_d = 1'b1;
    end
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      crd_d[k] = crd_q[k];
      ret_hit  = crd_ret_valid_i && (32'(crd_ret_vc_i) == k);
      inc      = ret_hit && (crd_q[k] != CRD_W'(CRD_INIT));
      dec      = gnt_en && gnt[k];
      if (ret_hit && !inc) begin
        crd_err_d = 1'b1;
      end
      if (inc && !dec) begin
        crd_d[k] = crd_q[k] + 1'b1;
      end else if (dec && !inc) begin
        crd_d[k] = crd_q[k] - 1'b1;
      end
    end
  end

  always_comb begin
    crd_cnt_o = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      crd_cnt_o[k*CRD_W +: CRD_W] = crd_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SCH_IDLE;
      rr_ptr_q  <= '0;
      crd_err_q <= 1'b0;
      tx_vc_q   <= '0;
      tx_len_q  <= '0;
      tx_msg_q  <= '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        crd_q[k] <= CRD_W'(CRD_INIT);
      end
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      crd_err_q <= crd_err_d;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        crd_q[k] <= crd_d[k];
      end
      if (gnt_en) begin
        tx_vc_q  <= M1_M2_CHANNEL_NUM_WIDTH'(gnt_idx);
        tx_len_q <= chan_len(32'(gnt_idx));
        tx_msg_q <= ch_msg_i[32'(gnt_idx)*MSG_W +: MSG_W];
      end
    end
  end

endmodule
